// File: rtl/icosoc_mod_i2c_target_pkg.sv
// Shared definitions for the icosoc I2C target peripheral: FSM state
// encoding, status-word bit positions and the ctrl-bus status address.
// Optional build macro used by this block: I2C_TARGET_GLITCH_FILTER_EN.
package icosoc_mod_i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

  localparam int unsigned STATUS_BUSY      = 0;
  localparam int unsigned STATUS_ADDRESSED = 1;
  localparam int unsigned STATUS_WRITTEN   = 2;
  localparam int unsigned STATUS_NACK      = 3;
  localparam int unsigned STATUS_PTR_LSB   = 8;

  localparam logic [15:0] STATUS_ADDR = 16'h0100;

endpackage

// File: rtl/icosoc_mod_i2c_target_if.sv
// icosoc ctrl bus as seen by the I2C target peripheral.
//   ctrl_wr   [3:0]  byte write strobes (any set = write)
//   ctrl_rd          read request
//   ctrl_addr [15:0] word address
//   ctrl_wdat [31:0] write data
//   ctrl_rdat [31:0] read data
//   ctrl_done        one-cycle completion pulse
// master = CPU side, slave = peripheral side.
interface icosoc_mod_i2c_target_if;
  logic [3:0]  ctrl_wr;
  logic        ctrl_rd;
  logic [15:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;

  modport master (
    output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    input  ctrl_rdat, ctrl_done
  );

  modport slave (
    input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
    output ctrl_rdat, ctrl_done
  );
endinterface

// File: rtl/icosoc_mod_i2c_target_line_filter.sv
// i2c_line_filter: conditions one open-drain bus line (SCL or SDA).
// 2-flop synchronizer, then (with I2C_TARGET_GLITCH_FILTER_EN defined) a
// filter whose output only follows after 4 equal consecutive samples,
// then single-cycle rise/fall pulses on the conditioned level.
// Latency line_i -> line_o: 2 clk unfiltered, 6 clk filtered.
//   clk, resetn  clock, asynchronous active-low reset
//   line_i       raw pin sense
//   line_o       conditioned level (resets to 1, the idle bus level)
//   rise, fall   one-cycle edge pulses of line_o
module i2c_line_filter (
  input  logic clk,
  input  logic resetn,
  input  logic line_i,
  output logic line_o,
  output logic rise,
  output logic fall
);
  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '1;
    else         sync_q <= {sync_q[0], line_i};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] hist_q;
  logic       filt_q;

  // The three history flops plus the current synchronized sample form the
  // 4-sample window; the output only moves when the window is unanimous.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[1:0], sync_q[1]};
      if ({hist_q, sync_q[1]} == 4'b1111)      filt_q <= 1'b1;
      else if ({hist_q, sync_q[1]} == 4'b0000) filt_q <= 1'b0;
    end
  end

  assign line_o = filt_q;
`else
  assign line_o = sync_q[1];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) prev_q <= 1'b1;
    else         prev_q <= line_o;
  end

  assign rise = line_o & ~prev_q;
  assign fall = ~line_o & prev_q;
endmodule

// File: rtl/icosoc_mod_i2c_target.sv
// icosoc_mod_i2c_target: I2C target (slave) with an 8-bit register file
// shared between the I2C bus and the CPU ctrl bus.
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN (input spike filter).
//   clk      system clock (>= 20x SCL)
//   resetn   asynchronous active-low reset
//   ctrl     ctrl bus (slave modport): regs at 0..REG_COUNT-1, status at 16'h0100
//   scl_i    SCL pin sense
//   sda_i    SDA pin sense
//   sda_oe   1 = pull SDA low, 0 = release
// Status: [0] busy, [1] addressed (W1C), [2] written by I2C (W1C),
//         [3] last read byte NACKed, [15:8] pointer.
module icosoc_mod_i2c_target
  import icosoc_mod_i2c_target_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR  = 7'h42,
  parameter int unsigned REG_COUNT = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  icosoc_mod_i2c_target_if.slave ctrl,
  input  logic                   scl_i,
  input  logic                   sda_i,
  output logic                   sda_oe
);
  localparam int unsigned PTR_W = $clog2(REG_COUNT);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_filter u_scl (
    .clk(clk), .resetn(resetn), .line_i(scl_i),
    .line_o(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter u_sda (
    .clk(clk), .resetn(resetn), .line_i(sda_i),
    .line_o(sda), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_cond, stop_cond;
  assign start_cond = sda_fall & scl;
  assign stop_cond  = sda_rise & scl;

  state_t           state, state_nxt;
  logic [3:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic             rw, rw_nxt;
  logic             nack, nack_nxt;
  logic             oe_nxt;
  logic             i2c_we;
  logic             set_addressed;
  logic [7:0]       shift_byte;
  logic [7:0]       regs [REG_COUNT];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      nack    <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      ptr     <= ptr_nxt;
      rw      <= rw_nxt;
      nack    <= nack_nxt;
      sda_oe  <= oe_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    ptr_nxt       = ptr;
    rw_nxt        = rw;
    nack_nxt      = nack;
    oe_nxt        = sda_oe;
    i2c_we        = 1'b0;
    set_addressed = 1'b0;
    shift_byte    = {shreg[6:0], sda};

    if (start_cond) begin
      state_nxt   = ST_ADDR;
      bit_cnt_nxt = '0;
      oe_nxt      = 1'b0;
    end else if (stop_cond) begin
      state_nxt = ST_IDLE;
      oe_nxt    = 1'b0;
    end else begin
      unique case (state)
        ST_ADDR, ST_SUB, ST_WDATA: begin
          if (scl_rise) begin
            shreg_nxt   = shift_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (state == ST_ADDR) begin
                if (shift_byte[7:1] == I2C_ADDR) begin
                  state_nxt     = ST_ADDR_ACK;
                  rw_nxt        = shift_byte[0];
                  set_addressed = 1'b1;
                end else begin
                  state_nxt = ST_IGNORE;
                end
              end else if (state == ST_SUB) begin
                state_nxt = ST_SUB_ACK;
                ptr_nxt   = shift_byte[PTR_W-1:0];
              end else begin
                state_nxt = ST_WDATA_ACK;
                i2c_we    = 1'b1;
                ptr_nxt   = ptr + PTR_W'(1);
              end
            end
          end
        end

        // Entered on the 8th rise with SDA released: the first fall starts
        // the ACK, the second fall (after the 9th rise) ends it.
        ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              oe_nxt = 1'b1;
            end else begin
              oe_nxt      = 1'b0;
              bit_cnt_nxt = '0;
              if (state == ST_ADDR_ACK && rw) begin
                state_nxt = ST_RDATA;
                shreg_nxt = regs[ptr];
                oe_nxt    = ~regs[ptr][7];
              end else if (state == ST_ADDR_ACK) begin
                state_nxt = ST_SUB;
              end else begin
                state_nxt = ST_WDATA;
              end
            end
          end
        end

        // Bit 7 went out on entry; bit_cnt counts rises, so at a fall it
        // names the next bit to present (7 - bit_cnt == ~bit_cnt[2:0]).
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              oe_nxt    = 1'b0;
              state_nxt = ST_RDATA_ACK;
            end else begin
              oe_nxt = ~shreg[~bit_cnt[2:0]];
            end
          end
        end

        // Entered on a fall, so any fall seen here follows the ACK rise.
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            ptr_nxt  = ptr + PTR_W'(1);
            nack_nxt = sda;
            if (sda) state_nxt = ST_IGNORE;
          end else if (scl_fall) begin
            state_nxt   = ST_RDATA;
            bit_cnt_nxt = '0;
            shreg_nxt   = regs[ptr];
            oe_nxt      = ~regs[ptr][7];
          end
        end

        default: ;
      endcase
    end
  end

  // ctrl bus side
  logic             cpu_req, cpu_wr, cpu_rd;
  logic             cpu_reg_hit, cpu_status_hit;
  logic [PTR_W-1:0] cpu_idx;
  logic             clr_addressed, clr_written;
  logic             addressed, written;
  logic             done_q;
  logic [31:0]      rdat_q;
  logic [31:0]      status;
  logic             unused_wdat;

  assign cpu_req        = (|ctrl.ctrl_wr | ctrl.ctrl_rd) & ~done_q;
  assign cpu_wr         = cpu_req & (|ctrl.ctrl_wr);
  assign cpu_rd         = cpu_req & ~(|ctrl.ctrl_wr);
  assign cpu_reg_hit    = ctrl.ctrl_addr < 16'(REG_COUNT);
  assign cpu_status_hit = ctrl.ctrl_addr == STATUS_ADDR;
  assign cpu_idx        = ctrl.ctrl_addr[PTR_W-1:0];
  assign clr_addressed  = cpu_wr & cpu_status_hit & ctrl.ctrl_wdat[STATUS_ADDRESSED];
  assign clr_written    = cpu_wr & cpu_status_hit & ctrl.ctrl_wdat[STATUS_WRITTEN];
  assign unused_wdat    = ^ctrl.ctrl_wdat[31:8];

  always_comb begin
    status                              = '0;
    status[STATUS_BUSY]                 = state != ST_IDLE;
    status[STATUS_ADDRESSED]            = addressed;
    status[STATUS_WRITTEN]              = written;
    status[STATUS_NACK]                 = nack;
    status[STATUS_PTR_LSB +: 8]         = 8'(ptr);
  end

  // The I2C write is issued after the CPU write so it wins a collision.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      if (cpu_wr && cpu_reg_hit) regs[cpu_idx] <= ctrl.ctrl_wdat[7:0];
      if (i2c_we)                regs[ptr]     <= shift_byte;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addressed <= 1'b0;
      written   <= 1'b0;
      done_q    <= 1'b0;
      rdat_q    <= '0;
    end else begin
      addressed <= set_addressed | (addressed & ~clr_addressed);
      written   <= i2c_we | (written & ~clr_written);
      done_q    <= cpu_req;
      if (cpu_rd) begin
        if (cpu_reg_hit)         rdat_q <= {24'h0, regs[cpu_idx]};
        else if (cpu_status_hit) rdat_q <= status;
        else                     rdat_q <= '0;
      end
    end
  end

  assign ctrl.ctrl_done = done_q;
  assign ctrl.ctrl_rdat = rdat_q;
endmodule

// File: tb/tb_icosoc_mod_i2c_target.sv
// Directed bench for icosoc_mod_i2c_target: ctrl-bus vector table followed
// by bit-banged I2C master sequences on an open-drain wired-AND SDA.
`timescale 1ns/1ps
module tb_icosoc_mod_i2c_target;
  localparam int unsigned Q = 10;  // quarter SCL period in clk cycles
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int unsigned LAT  = 6;
  localparam bit          FILT = 1'b1;
`else
  localparam int unsigned LAT  = 2;
  localparam bit          FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe;
  logic sda_i;

  icosoc_mod_i2c_target_if bus();

  assign sda_i = sda_m & ~sda_oe;

  icosoc_mod_i2c_target #(.I2C_ADDR(7'h42), .REG_COUNT(16)) dut (
    .clk(clk), .resetn(resetn), .ctrl(bus),
    .scl_i(scl_m), .sda_i(sda_i), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [31:0] d);
    bus.ctrl_wr = 4'hF; bus.ctrl_addr = a; bus.ctrl_wdat = d;
    @(negedge clk);
    bus.ctrl_wr = '0;
    check("wr_done", 32'(bus.ctrl_done), 32'd1);
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [31:0] d);
    bus.ctrl_rd = 1'b1; bus.ctrl_addr = a;
    @(negedge clk);
    bus.ctrl_rd = 1'b0;
    check("rd_done", 32'(bus.ctrl_done), 32'd1);
    d = bus.ctrl_rdat;
    @(negedge clk);
  endtask

  task automatic cpu_expect(input string name, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    cpu_read(a, d);
    check(name, d, exp);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; idle(Q);
    scl_m = 1'b1; idle(Q);
    sda_m = 1'b0; idle(Q);
    scl_m = 1'b0; idle(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; idle(Q);
    scl_m = 1'b1; idle(Q);
    sda_m = 1'b1; idle(2 * Q);
  endtask

  // mode 0: plain bit; 1: 2-clk low spike mid-high; 2: CPU writes reg[5]=0x11
  // in the clock where the target acts on this SCL rise.
  task automatic clock_bit(input logic b, input int mode, output logic s);
    sda_m = b; idle(Q);
    scl_m = 1'b1;
    if (mode == 1) begin
      idle(4); scl_m = 1'b0; idle(2); scl_m = 1'b1; idle(4);
    end else if (mode == 2) begin
      idle(LAT);
      bus.ctrl_wr = 4'hF; bus.ctrl_addr = 16'd5; bus.ctrl_wdat = 32'h11;
      idle(1);
      bus.ctrl_wr = '0;
      check("coll_cpu_done", 32'(bus.ctrl_done), 32'd1);
      idle(Q - LAT - 1);
    end else begin
      idle(Q);
    end
    s = sda_i;
    idle(Q);
    scl_m = 1'b0; idle(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int special_bit, input int mode,
                           output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], (i == special_bit) ? mode : 0, s);
    clock_bit(1'b1, 0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack_bit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 0, s);
      d[i] = s;
    end
    clock_bit(nack_bit, 0, s);
  endtask

  task automatic send_ack(input string name, input logic [7:0] b);
    logic ack;
    send_byte(b, -1, 0, ack);
    check(name, 32'(ack), 32'd1);
  endtask

  initial begin
    vec_t        vecs[13];
    logic        ack;
    logic [7:0]  d;
    int unsigned w;

    bus.ctrl_wr = '0; bus.ctrl_rd = 1'b0; bus.ctrl_addr = '0; bus.ctrl_wdat = '0;
    idle(3);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_done", 32'(bus.ctrl_done), 32'd0);
    check("rst_rdat", bus.ctrl_rdat, 32'd0);
    resetn = 1'b1;
    idle(3);

    vecs[0]  = '{1'b0, 16'h0100, 32'h0,   32'h0};
    vecs[1]  = '{1'b1, 16'd2,    32'h5C,  32'h0};
    vecs[2]  = '{1'b0, 16'd2,    32'h0,   32'h5C};
    vecs[3]  = '{1'b1, 16'd17,   32'hEE,  32'h0};
    vecs[4]  = '{1'b0, 16'd17,   32'h0,   32'h0};
    vecs[5]  = '{1'b0, 16'd1,    32'h0,   32'h0};
    vecs[6]  = '{1'b1, 16'd15,   32'h1FF, 32'h0};
    vecs[7]  = '{1'b0, 16'd15,   32'h0,   32'hFF};
    vecs[8]  = '{1'b1, 16'd0,    32'h3C,  32'h0};
    vecs[9]  = '{1'b1, 16'd1,    32'hC3,  32'h0};
    vecs[10] = '{1'b0, 16'd0,    32'h0,   32'h3C};
    vecs[11] = '{1'b0, 16'h0101, 32'h0,   32'h0};
    vecs[12] = '{1'b0, 16'd1,    32'h0,   32'hC3};
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) cpu_write(vecs[i].addr, vecs[i].wdat);
      else cpu_expect($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // held request: accepted, blocked while done=1, accepted again
    bus.ctrl_rd = 1'b1; bus.ctrl_addr = 16'd2;
    @(negedge clk); check("hold_done0", 32'(bus.ctrl_done), 32'd1);
    @(negedge clk); check("hold_done1", 32'(bus.ctrl_done), 32'd0);
    @(negedge clk); check("hold_done2", 32'(bus.ctrl_done), 32'd1);
    bus.ctrl_rd = 1'b0;
    @(negedge clk);

    // I2C write: sub 0x03, data A5 5A
    i2c_start;
    send_ack("w_addr_ack", 8'h84);
    send_ack("w_sub_ack", 8'h03);
    send_ack("w_d0_ack", 8'hA5);
    send_ack("w_d1_ack", 8'h5A);
    i2c_stop;
    cpu_expect("w_reg3", 16'd3, 32'hA5);
    cpu_expect("w_reg4", 16'd4, 32'h5A);
    cpu_expect("w_status", 16'h0100, 32'h0506);
    cpu_write(16'h0100, 32'h6);
    cpu_expect("w1c_status", 16'h0100, 32'h0500);

    // I2C read with repeated start, wrapping 15 -> 0 -> 1
    i2c_start;
    send_ack("r_addr_ack", 8'h84);
    send_ack("r_sub_ack", 8'h0F);
    i2c_start;
    send_ack("r_raddr_ack", 8'h85);
    read_byte(1'b0, d); check("r_byte0", 32'(d), 32'hFF);
    read_byte(1'b0, d); check("r_byte1", 32'(d), 32'h3C);
    read_byte(1'b1, d); check("r_byte2", 32'(d), 32'hC3);
    i2c_stop;
    cpu_expect("r_status", 16'h0100, 32'h020A);
    cpu_write(16'h0100, 32'h6);

    // wrong address
    i2c_start;
    send_byte(8'h86, -1, 0, ack);
    check("wa_no_ack", 32'(ack), 32'd0);
    send_byte(8'h00, -1, 0, ack);
    i2c_stop;
    cpu_expect("wa_status", 16'h0100, 32'h0208);
    cpu_expect("wa_reg0", 16'd0, 32'h3C);
    cpu_expect("wa_reg2", 16'd2, 32'h5C);

    // CPU and I2C write reg[5] in the same clock
    i2c_start;
    send_ack("c_addr_ack", 8'h84);
    send_ack("c_sub_ack", 8'h05);
    send_byte(8'h22, 0, 2, ack);
    check("c_data_ack", 32'(ack), 32'd1);
    i2c_stop;
    cpu_expect("c_reg5", 16'd5, 32'h22);
    cpu_expect("c_status", 16'h0100, 32'h060E);

    // reset while the target drives SDA during a read (reg0 bit7 = 0)
    i2c_start;
    send_ack("x_addr_ack", 8'h84);
    send_ack("x_sub_ack", 8'h00);
    i2c_start;
    send_ack("x_raddr_ack", 8'h85);
    w = 0;
    while (!sda_oe && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("x_driving", 32'(sda_oe), 32'd1);
    #2 resetn = 1'b0;
    #1 check("x_rst_release", 32'(sda_oe), 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    idle(3);
    resetn = 1'b1;
    idle(10);
    cpu_expect("x_status", 16'h0100, 32'h0);
    i2c_start;
    send_ack("x2_addr_ack", 8'h84);
    send_ack("x2_sub_ack", 8'h07);
    send_ack("x2_data_ack", 8'h99);
    i2c_stop;
    cpu_expect("x2_reg7", 16'd7, 32'h99);
    cpu_expect("x2_reg0", 16'd0, 32'h0);

    // 2-clk SCL low spike during the high phase of data bit 4 (0xB4)
    i2c_start;
    send_ack("f_addr_ack", 8'h84);
    send_ack("f_sub_ack", 8'h08);
    send_byte(8'hB4, 4, 1, ack);
    i2c_stop;
    cpu_expect("f_reg8", 16'd8, FILT ? 32'hB4 : 32'hBA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
